// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   // Buffer geometry: two entries, count needs one extra bit to express "full"
   localparam int          FETCH_BUF_DEPTH = 2;
   localparam int          FETCH_PTR_W     = $clog2(FETCH_BUF_DEPTH);
   localparam int          FETCH_CNT_W     = $clog2(FETCH_BUF_DEPTH + 1);

   localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
   localparam logic [31:0] PC_STEP         = 32'd4;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        misaligned;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Two-entry synchronous FIFO holding fetched {instr, pc} pairs.
//            Flush has priority over push/pop; head is read from storage
//            registers so nothing downstream sees the memory combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  fetch_entry_t           i_wr_entry,
   output logic [FETCH_CNT_W-1:0] o_count,
   output logic                   o_head_valid,
   output fetch_entry_t           o_head
);

   localparam logic [FETCH_CNT_W-1:0] c_FULL = FETCH_CNT_W'(FETCH_BUF_DEPTH);
   localparam logic [FETCH_CNT_W-1:0] c_ONE  = FETCH_CNT_W'(1);
   localparam logic [FETCH_PTR_W-1:0] c_PTR1 = FETCH_PTR_W'(1);

   fetch_entry_t [FETCH_BUF_DEPTH-1:0] r_mem;
   logic [FETCH_PTR_W-1:0]             r_wr_ptr;
   logic [FETCH_PTR_W-1:0]             r_rd_ptr;
   logic [FETCH_CNT_W-1:0]             r_count;
   logic                               w_push_ok;
   logic                               w_pop_ok;

   // Guard against overflow/underflow even if the caller misbehaves
   assign w_push_ok = i_push && ((r_count < c_FULL) || i_pop);
   assign w_pop_ok  = i_pop && (r_count != '0);

   // Storage, pointers and occupancy; flush empties without touching storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wr_entry;
            r_wr_ptr        <= r_wr_ptr + c_PTR1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + c_PTR1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + c_ONE;
            2'b01:   r_count <= r_count - c_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count      = r_count;
   assign o_head_valid = (r_count != '0);
   assign o_head       = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Owns the PC, drives instruction memory, buffers fetched words
//            and hands them to decode over valid/ready. Redirects flush.
//            Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect
//            yields a single marker entry and halts fetch until an aligned
//            redirect; otherwise low redirect bits are masked.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,  // must be 4-byte aligned
   parameter int          XLEN     = 32              // only 32 supported
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_plus4,
   output logic            out_misaligned
);

   localparam logic [FETCH_CNT_W-1:0] c_FULL = FETCH_CNT_W'(FETCH_BUF_DEPTH);

   fetch_state_t           r_state;
   fetch_state_t           w_state_next;
   logic [31:0]            r_pc;
   logic [31:0]            w_redirect_target;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_fetch_push;
   logic                   w_flush;
   fetch_entry_t           w_entry;
   fetch_entry_t           w_head;
   logic                   w_head_valid;
   logic [FETCH_CNT_W-1:0] w_count;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic                   w_redirect_mis;
   logic                   r_marker_pending;

   assign w_redirect_target = redirect_pc;
   assign w_redirect_mis    = (redirect_pc[1:0] != 2'b00);
`else
   assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

   assign w_pop = w_head_valid && out_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_BOOT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and buffer controls; redirect overrides every state
   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      w_fetch_push = 1'b0;
      w_flush      = 1'b0;
      w_entry      = '{instr: imem_data, pc: r_pc, misaligned: 1'b0};
      if (redirect_valid) begin
         w_flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
         w_state_next = w_redirect_mis ? S_HALT : S_RUN;
`else
         w_state_next = S_RUN;
`endif
      end else begin
         case (r_state)
            S_BOOT: begin
               w_state_next = S_RUN;
            end
            S_RUN: begin
               w_fetch_push = (w_count < c_FULL) || w_pop;
               w_push       = w_fetch_push;
            end
            S_HALT: begin
`ifdef FETCH_MISALIGN_TRAP_EN
               if (r_marker_pending) begin
                  w_push  = 1'b1;
                  w_entry = '{instr: NOP_INSTR, pc: r_pc, misaligned: 1'b1};
               end
`else
               w_state_next = S_RUN;
`endif
            end
            default: begin
               w_state_next = S_BOOT;
            end
         endcase
      end
   end

   // Program counter: redirect load, otherwise advance on each fetch push
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (redirect_valid) begin
         r_pc <= w_redirect_target;
      end else if (w_fetch_push) begin
         r_pc <= r_pc + PC_STEP;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // Marker request: armed by a misaligned redirect, consumed by its push
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_marker_pending <= 1'b0;
      end else if (redirect_valid) begin
         r_marker_pending <= w_redirect_mis;
      end else if (r_state == S_HALT) begin
         r_marker_pending <= 1'b0;
      end
   end
`endif

   fetch_buffer u_fetch_buffer (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (w_flush),
      .i_push       (w_push),
      .i_pop        (w_pop),
      .i_wr_entry   (w_entry),
      .o_count      (w_count),
      .o_head_valid (w_head_valid),
      .o_head       (w_head)
   );

   assign imem_addr      = r_pc;
   assign out_valid      = w_head_valid;
   assign out_instr      = w_head.instr;
   assign out_pc         = w_head.pc;
   // Zero while empty so the reset image is all-zero
   assign out_pc_plus4   = w_head_valid ? (w_head.pc + PC_STEP) : '0;
   assign out_misaligned = w_head.misaligned;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Directed self-checking bench for instruction_fetch with an
//            expected-PC scoreboard and a combinational memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic        out_misaligned;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   // Memory contents: four program words at 0..12, address-derived elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] prog [4];
      prog = '{32'h00a00093, 32'h00400113, 32'h00112223, 32'h00412103};
      if (a < 32'd16) return prog[a[3:2]];
      return a ^ 32'h1357_9BDF;
   endfunction

   assign imem_data = mem_word(imem_addr);

   instruction_fetch #(.RESET_PC(32'h0), .XLEN(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4),
      .out_misaligned (out_misaligned)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
   endtask

   // Compare every accepted head against the scoreboard, then stop accepting
   task automatic drain(input int budget);
      int cyc;
      cyc = 0;
      while (sb_q.size() > 0 && cyc < budget) begin
         if (out_valid && out_ready) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            chk("head_pc",    out_pc,       e);
            chk("head_instr", out_instr,    mem_word(e));
            chk("head_plus4", out_pc_plus4, e + 32'd4);
            chk("head_mis",   {31'b0, out_misaligned}, 32'd0);
         end
         @(negedge clk);
         cyc++;
      end
      n_tests++;
      assert (sb_q.size() == 0) else begin
         n_fail++;
         $error("FAIL drain_timeout: observed %0d pending expected 0", sb_q.size());
         sb_q.delete();
      end
      out_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      @(negedge clk);
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
   endtask

   initial begin
      // Reset image
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_pc",    out_pc, 32'h0);
      chk("rst_plus4", out_pc_plus4, 32'h0);
      chk("rst_mis",   {31'b0, out_misaligned}, 32'd0);
      chk("rst_addr",  imem_addr, 32'h0);

      // Boot cycle then streaming fetch
      rst = 1'b0;
      chk("boot_addr", imem_addr, 32'h0);
      @(negedge clk);
      chk("boot_idle", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b1;
      expect_seq(32'h0, 4);
      drain(20);

      // Backpressure: two entries held, PC parked at 8
      redirect(32'h0);
      chk("bp_flush_valid", {31'b0, out_valid}, 32'd0);
      repeat (5) @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_head",  out_pc, 32'h0);
      chk("bp_addr",  imem_addr, 32'h8);
      out_ready = 1'b1;
      expect_seq(32'h0, 4);
      drain(20);

      // Redirect with a full buffer
      repeat (3) @(negedge clk);
      chk("full_valid", {31'b0, out_valid}, 32'd1);
      redirect(32'h40);
      chk("redir_valid", {31'b0, out_valid}, 32'd0);
      chk("redir_addr",  imem_addr, 32'h40);
      @(negedge clk);
      chk("redir_rise", {31'b0, out_valid}, 32'd1);
      chk("redir_pc",   out_pc, 32'h40);
      out_ready = 1'b1;
      expect_seq(32'h40, 3);
      drain(20);

      // PC wrap-around
      redirect(32'hFFFF_FFFC);
      out_ready = 1'b1;
      expect_seq(32'hFFFF_FFFC, 3);
      drain(20);

      // Asynchronous reset mid-stream with a full buffer
      repeat (3) @(negedge clk);
      chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_valid", {31'b0, out_valid}, 32'd0);
      chk("async_addr",  imem_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      expect_seq(32'h0, 2);
      drain(20);

      // Misaligned redirect
      redirect(32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_flush", {31'b0, out_valid}, 32'd0);
      chk("mis_addr",  imem_addr, 32'h42);
      @(negedge clk);
      chk("mis_valid", {31'b0, out_valid}, 32'd1);
      chk("mis_pc",    out_pc, 32'h42);
      chk("mis_instr", out_instr, 32'h0000_0013);
      chk("mis_flag",  {31'b0, out_misaligned}, 32'd1);
      repeat (3) @(negedge clk);
      chk("halt_addr", imem_addr, 32'h42);
      chk("halt_pc",   out_pc, 32'h42);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("halt_empty", {31'b0, out_valid}, 32'd0);
      repeat (2) @(negedge clk);
      chk("halt_nopush", {31'b0, out_valid}, 32'd0);
      redirect(32'h80);
      out_ready = 1'b1;
      expect_seq(32'h80, 2);
      drain(20);
`else
      chk("mask_addr", imem_addr, 32'h40);
      out_ready = 1'b1;
      expect_seq(32'h40, 2);
      drain(20);
      chk("mask_mis", {31'b0, out_misaligned}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of instruction_memory. It owns the program counter and drives the memory address. It captures the combinational read data together with its PC into a 2-entry buffer, and presents it to decode over a valid/ready handshake. Decode/execute can redirect the PC (branch/jump), which flushes any buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
XLEN, 32, address/instruction width; only 32 supported.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
imem_addr  out  32  byte address to instruction_memory (memory uses addr>>2)
imem_data  in  32  instruction word; combinational, valid in the same cycle as imem_addr
redirect_valid  in  1  one-cycle pulse: load redirect_pc
redirect_pc  in  32  new fetch target
out_valid  out  1  buffer head holds an instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  head instruction word
out_pc  out  32  PC of head instruction
out_pc_plus4  out  32  out_pc + 4, wraps mod 2^32
out_misaligned  out  1  head is a misaligned-target marker (feature only; else tied 0)

Behaviour:
- Reset (async assert): pc=RESET_PC; buffer empty (count=0, rd/wr ptr=0); state=S_BOOT; out_valid=0; out_instr/out_pc/out_pc_plus4=0; out_misaligned=0.
- imem_addr = pc, combinational, always driven, including in S_BOOT.
- FSM:
  - S_BOOT: one idle cycle after reset release, no push. Then go to S_RUN.
  - S_RUN: normal fetch.
  - S_HALT: feature only; no push; left only by redirect or reset.
- Push condition: state==S_RUN && !redirect_valid && (count<2 || pop).
  - On push, write {imem_data, pc} at wr_ptr, then pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - Fetch-to-out_valid latency: 1 cycle. The instruction at address A appears at the head the cycle after A is on imem_addr.
- Pop = out_valid && out_ready. It advances rd_ptr.
  - Push and pop in the same cycle with count==2 is legal; count stays 2.
- Buffer full (count==2) and no pop: no push, pc holds, imem_addr stable.
- Buffer empty: out_valid=0. out_instr/out_pc hold their last values; don't-care, but must not be X after reset.
- Redirect priority over everything:
  - Buffer flushed (count=0, pointers reset) and pc <= redirect_pc.
  - No push that cycle. A pop in the same cycle is discarded; decode must ignore out_* in a redirect cycle.
  - The next cycle fetches from redirect_pc; out_valid rises one cycle after that.
- Redirect during S_BOOT: pc is loaded and the state still moves to S_RUN.
- Output registers are driven from the buffer head (registered storage); no combinational path from imem_data to out_*.
- Without the feature, redirect_pc[1:0] are forced to 2'b00 on load.
- An all-zero instruction word is passed through like any other; this block does not decode it.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: a redirect with redirect_pc[1:0]!=0 flushes the buffer and loads pc=redirect_pc unmodified.
  - It then pushes a single marker entry {instr=32'h0000_0013 (nop), pc=redirect_pc, misaligned=1} and enters S_HALT.
  - out_misaligned=1 while that marker is at the head.
  - S_HALT holds until an aligned redirect, which returns to S_RUN, or until reset.
- Undefined: no marker or S_HALT logic; low bits are masked; out_misaligned is tied 0.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {S_BOOT, S_RUN, S_HALT}
  - fetch_entry_t struct {instr[31:0], pc[31:0], misaligned}
  - constants: FETCH_BUF_DEPTH=2, NOP_INSTR=32'h0000_0013, PC_STEP=4
- One sub-module: fetch_buffer, a 2-entry synchronous FIFO with flush, push/pop, count and head outputs. It is instantiated once in instruction_fetch, which keeps the PC/FSM logic and the buffer logic separate.

Test Plan:
- Reset release, out_ready=1, memory preloaded {00a00093, 00400113, 00112223, 00412103}:
  - cycle 0 after release: imem_addr=0.
  - out_valid first rises with out_pc=0, out_instr=00a00093.
  - out_pc then steps 4, 8, 12 with the matching words; out_pc_plus4 = out_pc+4.
- Backpressure: hold out_ready=0 for 5 cycles -> exactly 2 entries buffered (pc 0, 4), imem_addr holds 8. On release, pcs 0, 4, 8 are delivered in order with no loss or duplication.
- Redirect with a full buffer: redirect_valid=1, redirect_pc=32'h40 -> next cycle out_valid=0, imem_addr=32'h40. The cycle after that, out_pc=32'h40.
- Wrap-around: redirect to 32'hFFFF_FFFC -> head pc FFFF_FFFC with out_pc_plus4=0, next head pc=0.
- Async reset mid-stream (rst pulse between edges, count=2) -> out_valid=0 and imem_addr=RESET_PC immediately, before the next clock edge.
- Misaligned redirect to 32'h42:
  - Feature on: single head {pc=42, instr=00000013, out_misaligned=1}, then no further pushes; a redirect to 32'h80 resumes fetch.
  - Feature off: fetch resumes at 32'h40.
